// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry circular buffer with valid/ready on both sides,
// synchronous flush and pre-decoded head fields. Optional same-cycle bypass: `IF_ID_BYPASS_EN.
module if_id_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned EXC_W  = 8,
   parameter int unsigned PRED_W = 36
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ID_Flush,
   input  logic                       IF_Valid,
   output logic                       IF_Ready,
   input  logic [31:0]                IF_Instr,
   input  logic [31:0]                IF_PC,
   input  logic [EXC_W-1:0]           IF_ExceptType,
   input  logic [PRED_W-1:0]          IF_PResult,
   output logic                       ID_Valid,
   input  logic                       ID_Ready,
   output logic [31:0]                ID_Instr,
   output logic [31:0]                ID_PC,
   output logic [15:0]                ID_Imm16,
   output logic [4:0]                 ID_rs,
   output logic [4:0]                 ID_rt,
   output logic [4:0]                 ID_rd,
   output logic [EXC_W-1:0]           ID_ExceptType,
   output logic [PRED_W-1:0]          ID_PResult,
   output logic [$clog2(DEPTH):0]     ID_Count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [31:0]       instr;
      logic [31:0]       pc;
      logic [EXC_W-1:0]  exc;
      logic [PRED_W-1:0] pred;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          in_entry;
   entry_t          head;
   entry_t          shown;
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   logic            bypass;
   logic            pass;
   logic            push;
   logic            pop;

   assign in_entry = '{instr: IF_Instr, pc: IF_PC, exc: IF_ExceptType, pred: IF_PResult};

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == CW'(0));
   // Ready depends only on registered occupancy, never on ID_Ready.
   assign IF_Ready = ~full & rst;

`ifdef IF_ID_BYPASS_EN
   assign bypass = empty & IF_Valid & ~ID_Flush & rst;
   assign pass   = bypass & ID_Ready;
`else
   assign bypass = 1'b0;
   assign pass   = 1'b0;
`endif

   // A passed-through instruction is consumed directly and never stored.
   assign push = IF_Valid & IF_Ready & ~ID_Flush & ~pass;
   assign pop  = ~empty & ID_Ready & ~ID_Flush;

   assign ID_Valid = (~empty & ~ID_Flush) | bypass;
   assign head     = bypass ? in_entry : mem[rptr];
   assign shown    = ID_Valid ? head : '0;

   assign ID_Instr      = shown.instr;
   assign ID_PC         = shown.pc;
   assign ID_ExceptType = shown.exc;
   assign ID_PResult    = shown.pred;
   assign ID_Imm16      = shown.instr[15:0];
   assign ID_rs         = shown.instr[25:21];
   assign ID_rt         = shown.instr[20:16];
   assign ID_rd         = shown.instr[15:11];
   assign ID_Count      = count;

   // Pointer and occupancy state; flush clears everything at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (ID_Flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_entry;
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (default build, DEPTH=4): directed tables,
// hand sequences and randomized traffic against a queue-based reference model.
module tb_if_id_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned EXC_W  = 8;
   localparam int unsigned PRED_W = 36;

   logic              clk;
   logic              rst;
   logic              ID_Flush;
   logic              IF_Valid;
   logic              IF_Ready;
   logic [31:0]       IF_Instr;
   logic [31:0]       IF_PC;
   logic [EXC_W-1:0]  IF_ExceptType;
   logic [PRED_W-1:0] IF_PResult;
   logic              ID_Valid;
   logic              ID_Ready;
   logic [31:0]       ID_Instr;
   logic [31:0]       ID_PC;
   logic [15:0]       ID_Imm16;
   logic [4:0]        ID_rs;
   logic [4:0]        ID_rt;
   logic [4:0]        ID_rd;
   logic [EXC_W-1:0]  ID_ExceptType;
   logic [PRED_W-1:0] ID_PResult;
   logic [2:0]        ID_Count;

   if_id_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W), .PRED_W(PRED_W)) dut (
      .clk(clk), .rst(rst), .ID_Flush(ID_Flush),
      .IF_Valid(IF_Valid), .IF_Ready(IF_Ready), .IF_Instr(IF_Instr), .IF_PC(IF_PC),
      .IF_ExceptType(IF_ExceptType), .IF_PResult(IF_PResult),
      .ID_Valid(ID_Valid), .ID_Ready(ID_Ready), .ID_Instr(ID_Instr), .ID_PC(ID_PC),
      .ID_Imm16(ID_Imm16), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
      .ID_ExceptType(ID_ExceptType), .ID_PResult(ID_PResult), .ID_Count(ID_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic [31:0]       instr;
      logic [31:0]       pc;
      logic [EXC_W-1:0]  exc;
      logic [PRED_W-1:0] pred;
   } item_t;

   typedef struct {
      logic        fl;
      logic        ifv;
      logic        idr;
      logic [31:0] pc;
      logic        ev;
      logic        er;
      logic [2:0]  ec;
      logic [31:0] epc;
   } vec_t;

   item_t q[$];
   vec_t  vec[20];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endfunction

   // Directed traffic uses a fixed encoding: instr/exc/pred all derive from the PC.
   function automatic item_t mk(logic [31:0] pc);
      item_t it;
      it.instr = 32'h8C43_0000 | pc;
      it.pc    = pc;
      it.exc   = pc[7:0];
      it.pred  = PRED_W'(pc);
      return it;
   endfunction

   task automatic drive(logic fl, logic ifv, logic idr, item_t it);
      ID_Flush      = fl;
      IF_Valid      = ifv;
      ID_Ready      = idr;
      IF_Instr      = it.instr;
      IF_PC         = it.pc;
      IF_ExceptType = it.exc;
      IF_PResult    = it.pred;
   endtask

   task automatic check_out(string tag, logic ev, logic er, logic [2:0] ec, item_t h);
      item_t e;
      e = ev ? h : '0;
      chk({tag, ".valid"}, 64'(ID_Valid), 64'(ev));
      chk({tag, ".ready"}, 64'(IF_Ready), 64'(er));
      chk({tag, ".count"}, 64'(ID_Count), 64'(ec));
      chk({tag, ".instr"}, 64'(ID_Instr), 64'(e.instr));
      chk({tag, ".pc"},    64'(ID_PC),    64'(e.pc));
      chk({tag, ".exc"},   64'(ID_ExceptType), 64'(e.exc));
      chk({tag, ".pred"},  64'(ID_PResult),    64'(e.pred));
      chk({tag, ".imm"},   64'(ID_Imm16), 64'(e.instr[15:0]));
      chk({tag, ".rs"},    64'(ID_rs),    64'(e.instr[25:21]));
      chk({tag, ".rt"},    64'(ID_rt),    64'(e.instr[20:16]));
      chk({tag, ".rd"},    64'(ID_rd),    64'(e.instr[15:11]));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      item_t it;
      item_t head;
      logic  fl, ifv, idr, ev, er;

      // Fill/backpressure, then flush with a live handshake on both sides.
      vec[0]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 3'd0, 32'h00};
      vec[1]  = '{1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 1'b1, 3'd1, 32'h10};
      vec[2]  = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 1'b1, 3'd2, 32'h10};
      vec[3]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 1'b1, 3'd3, 32'h10};
      vec[4]  = '{1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 3'd4, 32'h10};
      vec[5]  = '{1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 3'd4, 32'h10};
      vec[6]  = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 3'd4, 32'h10};
      vec[7]  = '{1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 1'b1, 3'd3, 32'h14};
      vec[8]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 3'd4, 32'h14};
      vec[9]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 3'd3, 32'h18};
      vec[10] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 3'd2, 32'h1C};
      vec[11] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 3'd1, 32'h20};
      vec[12] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 3'd0, 32'h00};
      vec[13] = '{1'b0, 1'b1, 1'b0, 32'h30, 1'b0, 1'b1, 3'd0, 32'h00};
      vec[14] = '{1'b0, 1'b1, 1'b0, 32'h34, 1'b1, 1'b1, 3'd1, 32'h30};
      vec[15] = '{1'b0, 1'b1, 1'b0, 32'h38, 1'b1, 1'b1, 3'd2, 32'h30};
      vec[16] = '{1'b1, 1'b1, 1'b1, 32'h3C, 1'b0, 1'b1, 3'd3, 32'h00};
      vec[17] = '{1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 3'd0, 32'h00};
      vec[18] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 3'd1, 32'h40};
      vec[19] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 3'd0, 32'h00};

      // Reset held 3 cycles with fetch offering; nothing may leak to ID.
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b1, mk(32'h100));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_out($sformatf("reset%0d", i), 1'b0, 1'b0, 3'd0, '0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Streaming with ID always ready: one-cycle latency, occupancy stays at 1.
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, k < 4, 1'b1, mk(32'(4 * k)));
         @(negedge clk);
         ev = (k >= 1) && (k <= 4);
         check_out($sformatf("stream%0d", k), ev, 1'b1, ev ? 3'd1 : 3'd0,
                   mk(32'(4 * (k - 1))));
         next_cycle();
      end

      for (int i = 0; i < 20; i++) begin
         drive(vec[i].fl, vec[i].ifv, vec[i].idr, mk(vec[i].pc));
         @(negedge clk);
         check_out($sformatf("vec%0d", i), vec[i].ev, vec[i].er, vec[i].ec, mk(vec[i].epc));
         next_cycle();
      end

      // Randomized traffic with stalls and rare flushes, across many pointer wraps.
      q.delete();
      for (int c = 0; c < 300; c++) begin
         fl       = ($urandom_range(15) == 0);
         ifv      = 1'($urandom_range(1));
         idr      = ($urandom_range(3) != 0);
         it.instr = $urandom();
         it.pc    = $urandom();
         it.exc   = EXC_W'($urandom());
         it.pred  = PRED_W'({$urandom(), $urandom()});
         drive(fl, ifv, idr, it);
         @(negedge clk);
         ev   = (q.size() != 0) && !fl;
         er   = (q.size() != DEPTH);
         head = (q.size() != 0) ? q[0] : '0;
         check_out($sformatf("rnd%0d", c), ev, er, 3'(q.size()), head);
         if (fl) q.delete();
         else begin
            if (ev && idr) void'(q.pop_front());
            if (ifv && er) q.push_back(it);
         end
         next_cycle();
      end

      // Async reset between edges with two entries held.
      drive(1'b1, 1'b0, 1'b0, '0);
      next_cycle();
      drive(1'b0, 1'b1, 1'b0, mk(32'h200));
      next_cycle();
      drive(1'b0, 1'b1, 1'b0, mk(32'h204));
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, '0);
      #2;
      check_out("pre_areset", 1'b1, 1'b1, 3'd2, mk(32'h200));
      rst = 1'b0;
      #1;
      check_out("areset", 1'b0, 1'b0, 3'd0, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b0, mk(32'h300));
      @(negedge clk);
      check_out("post_areset", 1'b0, 1'b1, 3'd0, '0);
      next_cycle();
      drive(1'b0, 1'b0, 1'b1, '0);
      @(negedge clk);
      check_out("post_areset_pop", 1'b1, 1'b1, 3'd1, mk(32'h300));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
